matrix_row_packer: RTL and testbench

//  Upstream loader for sram_matrix_buffer_wide.
//  - Accepts a byte-serial weight/activation stream on a valid/ready handshake.
//  - Packs ARR_WIDTH consecutive bytes into one wide row.
//  - Writes each row into the buffer at consecutive addresses from 0, using
//    the buffer's active-low enable/write strobes.
//  - Signals completion once the requested matrix height has been written.

---
 rtl/matrix_row_packer_pkg.sv | 16 +
 rtl/matrix_row_packer.sv | 162 ++++++++++++++++
 tb/tb_matrix_row_packer.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_row_packer_pkg.sv
// Shared definitions for the matrix row packer and the wide matrix buffer.
//   ARR_WIDTH  : lanes per row (bytes per buffer word)
//   ADDR_DEPTH : number of buffer rows
//   ADDR_W     : buffer address width
//   COL_W      : lane index width
//   row_t      : one packed buffer row, lane 0 in the low byte
package matrix_row_packer_pkg;

    localparam int unsigned ARR_WIDTH  = 16;
    localparam int unsigned ADDR_DEPTH = 128;
    localparam int unsigned ADDR_W     = $clog2(ADDR_DEPTH);
    localparam int unsigned COL_W      = $clog2(ARR_WIDTH);

    typedef logic [ARR_WIDTH-1:0][7:0] row_t;

endpackage

// File: rtl/matrix_row_packer.sv
// matrix_row_packer
// Packs a byte-serial valid/ready stream into ARR_WIDTH-byte rows and writes
// them into sram_matrix_buffer_wide at consecutive addresses starting at 0.
// Ports:
//   clk, reset       : rising-edge clock, synchronous active-high reset
//   start, num_rows  : begin a load of num_rows rows (clamped to ADDR_DEPTH)
//   in_valid/in_data/in_last/in_ready : byte stream; in_last ends the matrix
//   sram_enable_n, sram_wr_en_n, sram_addr, sram_wdata : buffer write port
//   busy, done, rows_written : load status
module matrix_row_packer
    import matrix_row_packer_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [ADDR_W:0]           num_rows,
    input  logic                      in_valid,
    input  logic [7:0]                in_data,
    input  logic                      in_last,
    output logic                      in_ready,
    output logic                      sram_enable_n,
    output logic                      sram_wr_en_n,
    output logic [ADDR_W-1:0]         sram_addr,
    output logic [ARR_WIDTH*8-1:0]    sram_wdata,
    output logic                      busy,
    output logic                      done,
    output logic [ADDR_W:0]           rows_written
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        DONE
    } state_e;

    localparam logic [ADDR_W:0] MAX_ROWS = (ADDR_W+1)'(ADDR_DEPTH);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(ARR_WIDTH - 1);

    state_e              state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ADDR_W-1:0]   row_q, row_d;
    logic [ADDR_W:0]     target_q, target_d;
    logic                last_q, last_d;
    row_t                lanes_q, lanes_d;
    row_t                fill_row;
    logic                en_n_q, en_n_d;
    logic                wr_n_q, wr_n_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    row_t                wdata_q, wdata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [ADDR_W:0]     rows_written_q, rows_written_d;

    assign in_ready      = (state_q == FILL);
    assign sram_enable_n = en_n_q;
    assign sram_wr_en_n  = wr_n_q;
    assign sram_addr     = addr_q;
    assign sram_wdata    = wdata_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign rows_written  = rows_written_q;

    always_comb begin
        state_d        = state_q;
        col_d          = col_q;
        row_d          = row_q;
        target_d       = target_q;
        last_d         = last_q;
        lanes_d        = lanes_q;
        en_n_d         = 1'b1;
        wr_n_d         = 1'b1;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        rows_written_d = rows_written_q;

        fill_row          = lanes_q;
        fill_row[col_q]   = in_data;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    target_d       = (num_rows > MAX_ROWS) ? MAX_ROWS : num_rows;
                    col_d          = '0;
                    row_d          = '0;
                    rows_written_d = '0;
                    last_d         = 1'b0;
                    lanes_d        = '0;
                    state_d        = (num_rows == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                if (in_valid) begin
                    lanes_d = fill_row;
                    col_d   = col_q + COL_W'(1);
                    if (col_q == LAST_COL || in_last) begin
                        // Strobes and row are registered here so they are
                        // stable for the whole WRITE cycle. Clearing the lane
                        // register gives zero-fill for a row cut short by in_last.
                        state_d = WRITE;
                        en_n_d  = 1'b0;
                        wr_n_d  = 1'b0;
                        addr_d  = row_q;
                        wdata_d = fill_row;
                        last_d  = in_last;
                        col_d   = '0;
                        lanes_d = '0;
                    end
                end
            end
            WRITE: begin
                rows_written_d = rows_written_q + (ADDR_W+1)'(1);
                if (last_q || ({1'b0, row_q} + (ADDR_W+1)'(1) == target_q)) begin
                    state_d = DONE;
                end else begin
                    row_d   = row_q + ADDR_W'(1);
                    state_d = FILL;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            col_q          <= '0;
            row_q          <= '0;
            target_q       <= '0;
            last_q         <= 1'b0;
            lanes_q        <= '0;
            en_n_q         <= 1'b1;
            wr_n_q         <= 1'b1;
            addr_q         <= '0;
            wdata_q        <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            rows_written_q <= '0;
        end else begin
            state_q        <= state_d;
            col_q          <= col_d;
            row_q          <= row_d;
            target_q       <= target_d;
            last_q         <= last_d;
            lanes_q        <= lanes_d;
            en_n_q         <= en_n_d;
            wr_n_q         <= wr_n_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            rows_written_q <= rows_written_d;
        end
    end

endmodule

// File: tb/tb_matrix_row_packer.sv
// Testbench for matrix_row_packer with a behavioural model of the wide buffer.
module tb_matrix_row_packer;
    import matrix_row_packer_pkg::*;

    typedef struct {
        int   addr;
        row_t data;
    } wr_t;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   start;
    logic [ADDR_W:0]        num_rows;
    logic                   in_valid;
    logic [7:0]             in_data;
    logic                   in_last;
    logic                   in_ready;
    logic                   sram_enable_n;
    logic                   sram_wr_en_n;
    logic [ADDR_W-1:0]      sram_addr;
    logic [ARR_WIDTH*8-1:0] sram_wdata;
    logic                   busy;
    logic                   done;
    logic [ADDR_W:0]        rows_written;

    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;
    int done_cnt = 0;
    int done_edge = 0;

    wr_t        exp_wr_q[$];
    int         exp_done_q[$];
    logic [7:0] bytes_q[$];
    row_t       mem[ADDR_DEPTH];

    matrix_row_packer dut (
        .clk(clk), .reset(reset), .start(start), .num_rows(num_rows),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .sram_enable_n(sram_enable_n),
        .sram_wr_en_n(sram_wr_en_n), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .busy(busy), .done(done),
        .rows_written(rows_written)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Buffer model: captures on the edge that ends a strobed cycle.
    always @(posedge clk) begin
        if (sram_enable_n === 1'b0 && sram_wr_en_n === 1'b0)
            mem[sram_addr] <= sram_wdata;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Write monitor: every strobed cycle must match the next expected row.
    always @(negedge clk) begin
        if (sram_wr_en_n === 1'b0) begin
            chk("wr_enable_n", 128'(sram_enable_n), 128'(0));
            chk("ready_in_write", 128'(in_ready), 128'(0));
            if (exp_wr_q.size() == 0) begin
                chk("unexpected_write", 128'(sram_addr), 128'hx);
            end else begin
                wr_t e;
                e = exp_wr_q.pop_front();
                chk("wr_addr", 128'(sram_addr), 128'(e.addr));
                chk("wr_data", 128'(sram_wdata), 128'(e.data));
            end
        end
    end

    // Done monitor.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt  = done_cnt + 1;
            done_edge = edge_cnt;
            chk("busy_in_done", 128'(busy), 128'(1));
            if (exp_done_q.size() == 0) begin
                chk("unexpected_done", 128'(rows_written), 128'hx);
            end else begin
                chk("rows_written", 128'(rows_written), 128'(exp_done_q.pop_front()));
            end
        end
    end

    task automatic gen_bytes(input int n, input bit seq);
        bytes_q.delete();
        for (int i = 0; i < n; i++)
            bytes_q.push_back(seq ? 8'(i + 1) : 8'($urandom_range(255)));
    endtask

    // Reference: rows are consecutive 16-byte chunks of the stream, at most
    // min(nreq,128) of them, the stream stopping after last_pos; a partial
    // final row is zero padded. A reset at abort_at loses the partial row.
    task automatic expect_model(input int nreq, input int last_pos, input int abort_at,
                                output int consumed);
        int  nr;
        int  nrows;
        bit  stop;
        nr = (nreq > ADDR_DEPTH) ? ADDR_DEPTH : nreq;
        consumed = 0;
        nrows = 0;
        stop = 0;
        for (int r = 0; r < nr && !stop; r++) begin
            row_t row;
            bit   ended;
            bit   cut;
            wr_t  w;
            row = '0;
            ended = 0;
            cut = 0;
            for (int c = 0; c < ARR_WIDTH && !ended && !cut; c++) begin
                int idx;
                idx = r * ARR_WIDTH + c;
                if (abort_at >= 0 && idx >= abort_at) begin
                    cut = 1;
                end else begin
                    row[c] = bytes_q[idx];
                    consumed++;
                    if (idx == last_pos) ended = 1;
                end
            end
            if (cut) begin
                stop = 1;
            end else begin
                w.addr = r;
                w.data = row;
                exp_wr_q.push_back(w);
                nrows++;
                if (ended) stop = 1;
            end
        end
        if (abort_at < 0) exp_done_q.push_back(nrows);
    endtask

    task automatic run_load(input int nreq, input int last_pos, input int abort_at,
                            input int gap, input bit poke);
        int consumed;
        int idx;
        int dc0;
        int start_edge;
        bit acc;
        bit got;
        bit any;
        expect_model(nreq, last_pos, abort_at, consumed);
        dc0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b1;
        num_rows = (ADDR_W+1)'(nreq);
        @(posedge clk); #1;
        start_edge = edge_cnt;
        start = 1'b0;
        num_rows = (ADDR_W+1)'($urandom_range(255));
        idx = 0;
        got = (done_cnt != dc0);
        for (int cyc = 0; cyc < 6000 && !got; cyc++) begin
            if (abort_at >= 0 && idx == abort_at) break;
            in_valid = (idx < bytes_q.size()) && ($urandom_range(99) >= gap);
            in_data  = (idx < bytes_q.size()) ? bytes_q[idx] : 8'h00;
            in_last  = (idx == last_pos);
            if (poke && cyc == 5) begin
                start = 1'b1;
                num_rows = (ADDR_W+1)'(1);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            got = (done_cnt != dc0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        start    = 1'b0;
        if (abort_at >= 0) begin
            chk("abort_reached", 128'(idx), 128'(abort_at));
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            chk("abort_en_n", 128'(sram_enable_n), 128'(1));
            chk("abort_wr_n", 128'(sram_wr_en_n), 128'(1));
            chk("abort_rows_written", 128'(rows_written), 128'(0));
            chk("abort_busy", 128'(busy), 128'(0));
            chk("abort_ready", 128'(in_ready), 128'(0));
        end else begin
            chk("done_seen", 128'(got), 128'(1));
            chk("bytes_consumed", 128'(idx), 128'(consumed));
            if (nreq == 0) begin
                checks++;
                if (!got || done_edge - start_edge > 2) begin
                    failures++;
                    $display("FAIL zero_done_latency actual=%0d required<=2",
                             done_edge - start_edge);
                end
            end
            // Offered bytes after completion must not be taken.
            any = 0;
            in_valid = 1'b1;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (in_ready) any = 1;
            end
            in_valid = 1'b0;
            chk("idle_no_accept", 128'(any), 128'(0));
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        row_t snap;
        row_t exp0;
        for (int i = 0; i < ADDR_DEPTH; i++) mem[i] = {ARR_WIDTH{8'hA5}};
        reset = 1'b1;
        start = 1'b0;
        num_rows = '0;
        in_valid = 1'b0;
        in_data = 8'h00;
        in_last = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 128'(in_ready), 128'(0));
        chk("rst_en_n", 128'(sram_enable_n), 128'(1));
        chk("rst_wr_n", 128'(sram_wr_en_n), 128'(1));
        chk("rst_addr", 128'(sram_addr), 128'(0));
        chk("rst_wdata", 128'(sram_wdata), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_rows_written", 128'(rows_written), 128'(0));
        // In IDLE a valid byte must not be consumed.
        in_valid = 1'b1;
        @(negedge clk);
        chk("idle_ready", 128'(in_ready), 128'(0));
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;

        // Single row 0x01..0x10, no gaps.
        gen_bytes(ARR_WIDTH, 1);
        run_load(1, -1, -1, 0, 0);
        for (int c = 0; c < ARR_WIDTH; c++) exp0[c] = 8'(c + 1);
        chk("row0_readback", 128'(mem[0]), 128'(exp0));

        // Full depth with random gaps.
        gen_bytes(ADDR_DEPTH * ARR_WIDTH, 0);
        run_load(128, -1, -1, 30, 0);

        // Early in_last on the 5th byte of row 2; row 3 must be untouched.
        snap = mem[3];
        gen_bytes(4 * ARR_WIDTH, 0);
        run_load(4, 2 * ARR_WIDTH + 4, -1, 20, 0);
        chk("row3_untouched", 128'(mem[3]), 128'(snap));

        // in_last on the final lane of a row.
        gen_bytes(3 * ARR_WIDTH, 0);
        run_load(3, ARR_WIDTH - 1, -1, 10, 0);

        // Zero rows, then clamped oversize request.
        gen_bytes(8, 0);
        run_load(0, -1, -1, 0, 0);
        gen_bytes(ADDR_DEPTH * ARR_WIDTH + 20, 0);
        run_load(200, -1, -1, 0, 0);

        // Reset during FILL of row 5 of 10, then a fresh load.
        gen_bytes(10 * ARR_WIDTH, 0);
        run_load(10, -1, 5 * ARR_WIDTH + 3, 15, 0);
        gen_bytes(2 * ARR_WIDTH, 0);
        run_load(2, -1, -1, 15, 0);

        // start pulsed mid-load is ignored.
        gen_bytes(6 * ARR_WIDTH, 0);
        run_load(6, -1, -1, 10, 1);

        chk("wr_queue_empty", 128'(exp_wr_q.size()), 128'(0));
        chk("done_queue_empty", 128'(exp_done_q.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
